syn_sched: RTL and testbench
============================

SYN_SCHED -- requirements
Module: syn_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the slow-clock tick.
REQ-002 Parameter LOCK_EDGES, default 4: slow_clk rising edges required to declare lock.
REQ-003 Parameter WDOG_CYCLES, default 64: fast_clk cycles without a slow_clk rise before lock is declared lost.
REQ-004 fast_clk  input  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 slow_clk  input  1  asynchronous slow clock, treated as data and never used as a clock.
REQ-007 req  input  N_REQ  per-requester request, level-sensitive.
REQ-008 grant  output  N_REQ  one-hot or zero, registered, one fast_clk cycle wide.
REQ-009 tick  output  1  registered one-cycle pulse marking a qualified slow_clk rise.
REQ-010 locked  output  1  high while the state is LOCKED.
REQ-011 lost  output  1  high while the state is LOST.

Function
REQ-012 slow_clk SHALL pass through a 2-flop synchroniser (s1, s2) plus a history flop s3; rise = s2 & ~s3.
REQ-013 Edge latency: slow_clk sampled high at fast_clk edge k SHALL give rise during cycle k+2; tick/grant SHALL be high for exactly cycle k+3.
REQ-014 The FSM states SHALL be UNLOCKED, LOCKED and LOST; the reset state is UNLOCKED.
REQ-015 UNLOCKED: each rise SHALL increment edge_cnt; the rise that brings edge_cnt to LOCK_EDGES SHALL move the FSM to LOCKED and clear edge_cnt.
REQ-016 The transition rise into LOCKED SHALL NOT produce tick; the first tick comes on the next rise.
REQ-017 LOCKED: each rise SHALL pulse tick and grant exactly one requesting bit by round-robin, starting the search at the index after the last grant.
REQ-018 With req == 0 on a tick cycle, grant SHALL be 0, tick SHALL still pulse and the round-robin pointer SHALL be unchanged.
REQ-019 req SHALL be sampled in the cycle rise is high; req changes at other times SHALL have no effect.
REQ-020 The pointer SHALL wrap from N_REQ-1 to 0.
REQ-021 The watchdog counter SHALL clear on every rise and otherwise increment, saturating at WDOG_CYCLES; its width SHALL be $clog2(WDOG_CYCLES+1).
REQ-022 LOCKED: when the watchdog reaches WDOG_CYCLES, the FSM SHALL move to LOST in the following cycle.
REQ-023 UNLOCKED: when the watchdog reaches WDOG_CYCLES, edge_cnt SHALL clear to 0.
REQ-024 LOST: tick and grant SHALL stay 0; the first rise SHALL move the FSM to UNLOCKED with edge_cnt = 1.
REQ-025 If rise and watchdog terminal count occur in the same cycle, rise SHALL win: the counter clears and no state change to LOST occurs.
REQ-026 grant SHALL never have more than one bit set and SHALL be 0 whenever tick is 0.

Reset
REQ-027 While rst = 1, asynchronously: s1, s2 and s3 = 0; edge_cnt, watchdog and pointer = 0; tick, grant, locked and lost = 0; state = UNLOCKED.
REQ-028 Reset asserted mid-operation, including during a tick cycle, SHALL clear all state immediately; after release, relock SHALL need LOCK_EDGES fresh rises.

Configuration
REQ-029 Macro SYN_SCHED_WDOG_EN defined: the watchdog, LOST state and lost output SHALL operate per REQ-021 to REQ-025.
REQ-030 Macro SYN_SCHED_WDOG_EN undefined: no watchdog counter is built, LOST is unreachable, lost is tied 0, and LOCKED persists until reset.

Structure
REQ-031 Package syn_pkg SHALL hold the state enum (UNLOCKED, LOCKED, LOST) and the default values of N_REQ, LOCK_EDGES and WDOG_CYCLES.
REQ-032 The round-robin arbiter SHALL be a separate sub-module, syn_rr_arb, with inputs req, pointer and enable and outputs a one-hot grant and the next pointer.

Verification
REQ-033 Stimulus: fast_clk period 8 ns, slow_clk period 42 ns, rst high from 5 ns to 67 ns -> locked rises on the 4th slow_clk rise after release; no tick before it.
REQ-034 Stimulus: locked, req = 4'b1111 -> grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive ticks, each tick 1 cycle wide, 3 fast_clk edges after the slow_clk rise is sampled.
REQ-035 Stimulus: locked, req = 4'b0000 on one tick, then 4'b0100 -> grant = 0 with tick = 1, then grant = 0100.
REQ-036 Stimulus: macro defined, slow_clk stopped low after lock -> lost = 1 and locked = 0 after 64 cycles; on restart, locked returns after 4 rises.
REQ-037 Stimulus: macro undefined, slow_clk stopped for 200 cycles -> lost = 0 and locked stays 1 throughout.
REQ-038 Stimulus: rst pulsed for 3 ns during a tick cycle -> all outputs 0 immediately; after release, relock needs 4 rises.

Source files
------------

// File: rtl/syn_pkg.sv
// syn_pkg: lock-state encoding and default sizing shared by the syn_sched slice.
`timescale 1ns/1ps
package syn_pkg;
   typedef enum logic [1:0] {UNLOCKED, LOCKED, LOST} state_e;
   localparam int N_REQ_DEF       = 4;
   localparam int LOCK_EDGES_DEF  = 4;
   localparam int WDOG_CYCLES_DEF = 64;
endpackage

// File: rtl/syn_rr_arb.sv
// syn_rr_arb: one-hot round-robin pick starting at ptr; ptr_nxt follows the winner.
`timescale 1ns/1ps
module syn_rr_arb
   import syn_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   input  logic             en,
   output logic [N_REQ-1:0] gnt,
   output logic [PW-1:0]    ptr_nxt
);
   int   idx;
   logic hit;
   always_comb begin
      gnt     = '0;
      ptr_nxt = ptr;
      hit     = 1'b0;
      idx     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(ptr) + i) % N_REQ;
         if (en && !hit && req[idx]) begin
            hit      = 1'b1;
            gnt[idx] = 1'b1;
            ptr_nxt  = PW'((idx + 1) % N_REQ);
         end
      end
   end
endmodule

// File: rtl/syn_sched.sv
// syn_sched: synchronises slow_clk, locks onto its rises and issues round-robin ticks.
// Define SYN_SCHED_WDOG_EN to build the loss-of-clock watchdog, LOST state and lost output.
`timescale 1ns/1ps
module syn_sched
   import syn_pkg::*;
#(
   parameter int N_REQ       = N_REQ_DEF,
   parameter int LOCK_EDGES  = LOCK_EDGES_DEF,
   parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
   input  logic             fast_clk,
   input  logic             rst,
   input  logic             slow_clk,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic             tick,
   output logic             locked,
   output logic             lost
);
   localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
   localparam int EW = $clog2(LOCK_EDGES + 1);

   state_e           state_q, state_d;
   logic             s1_q, s2_q, s3_q, rise, arb_en, wdog_hit;
   logic [EW-1:0]    edge_q, edge_d;
   logic [PW-1:0]    ptr_q, ptr_d, arb_ptr;
   logic [N_REQ-1:0] grant_q, grant_d, arb_gnt;
   logic             tick_q, tick_d, locked_q;

   assign rise   = s2_q & ~s3_q;
   assign arb_en = rise && state_q == LOCKED;

   syn_rr_arb #(.N_REQ(N_REQ)) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .en      (arb_en),
      .gnt     (arb_gnt),
      .ptr_nxt (arb_ptr)
   );

   // The rise that completes lock only changes state; ticks start on the next rise.
   always_comb begin
      state_d = state_q;
      edge_d  = edge_q;
      ptr_d   = arb_ptr;
      tick_d  = arb_en;
      grant_d = arb_gnt;
      case (state_q)
         UNLOCKED: begin
            if (rise) begin
               state_d = edge_q == EW'(LOCK_EDGES - 1) ? LOCKED : UNLOCKED;
               edge_d  = edge_q == EW'(LOCK_EDGES - 1) ? '0 : edge_q + 1'b1;
            end else if (wdog_hit) edge_d = '0;
         end
         LOCKED: if (!rise && wdog_hit) state_d = LOST;
         LOST: begin
            if (rise) begin
               state_d = UNLOCKED;
               edge_d  = EW'(1);
            end
         end
         default: state_d = UNLOCKED;
      endcase
   end

   always_ff @(posedge fast_clk or posedge rst) begin
      if (rst) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         state_q  <= UNLOCKED;
         edge_q   <= '0;
         ptr_q    <= '0;
         tick_q   <= 1'b0;
         grant_q  <= '0;
         locked_q <= 1'b0;
      end else begin
         s1_q     <= slow_clk;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         state_q  <= state_d;
         edge_q   <= edge_d;
         ptr_q    <= ptr_d;
         tick_q   <= tick_d;
         grant_q  <= grant_d;
         locked_q <= state_d == LOCKED;
      end
   end

`ifdef SYN_SCHED_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wdog_q, wdog_d;
   logic          lost_q, lost_d;
   assign wdog_hit = wdog_q == WW'(WDOG_CYCLES);
   assign wdog_d   = rise ? '0 : wdog_hit ? wdog_q : wdog_q + 1'b1;
   assign lost_d   = state_d == LOST;
   always_ff @(posedge fast_clk or posedge rst) begin
      if (rst) begin
         wdog_q <= '0;
         lost_q <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         lost_q <= lost_d;
      end
   end
   assign lost = lost_q;
`else
   assign wdog_hit = 1'b0;
   assign lost     = 1'b0;
`endif

   assign grant  = grant_q;
   assign tick   = tick_q;
   assign locked = locked_q;
endmodule

// File: tb/tb_syn_sched.sv
// tb_syn_sched: randomized and directed checks of syn_sched against a cycle-level reference model.
`timescale 1ns/1ps
module tb_syn_sched;
   localparam int N  = 4;
   localparam int LE = 4;
   localparam int WD = 64;
`ifdef SYN_SCHED_WDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif
   localparam int M_UNL = 0, M_LCK = 1, M_LST = 2;

   logic         fast_clk = 1'b0, rst = 1'b0, slow_clk = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] grant;
   logic         tick, locked, lost;

   int total = 0, bad = 0;
   bit slow_run = 1'b0, chk_en = 1'b0;
   int n_slow = 0;

   syn_sched #(.N_REQ(N), .LOCK_EDGES(LE), .WDOG_CYCLES(WD)) dut (
      .fast_clk (fast_clk),
      .rst      (rst),
      .slow_clk (slow_clk),
      .req      (req),
      .grant    (grant),
      .tick     (tick),
      .locked   (locked),
      .lost     (lost)
   );

   always #4 fast_clk = ~fast_clk;

   // slow_clk edges sit on half-ns points so they never coincide with fast_clk edges
   initial begin
      #0.5;
      forever begin
         #21;
         slow_clk = slow_run ? ~slow_clk : 1'b0;
      end
   end

   always @(posedge slow_clk) n_slow++;

   // Reference model: slow_clk sampled at edge k shows up as a rise seen at edge k+2
   bit           hist[$] = '{0, 0, 0};
   int           mode = M_UNL, edges = 0, wd = 0, last = N - 1;
   bit           m_rise, wd_term, found;
   bit           exp_tick = 1'b0, exp_locked = 1'b0, exp_lost = 1'b0;
   logic [N-1:0] exp_grant = '0;

   always @(posedge fast_clk or posedge rst) begin
      if (rst) begin
         hist = '{0, 0, 0};
         mode = M_UNL; edges = 0; wd = 0; last = N - 1;
         exp_tick = 1'b0; exp_grant = '0; exp_locked = 1'b0; exp_lost = 1'b0;
      end else begin
         m_rise    = hist[$-1] && !hist[$-2];
         wd_term   = WD_EN && wd == WD;
         exp_tick  = 1'b0;
         exp_grant = '0;
         if (mode == M_UNL) begin
            if (m_rise) begin
               edges++;
               if (edges == LE) begin mode = M_LCK; edges = 0; end
            end else if (wd_term) edges = 0;
         end else if (mode == M_LCK) begin
            if (m_rise) begin
               exp_tick = 1'b1;
               found = 1'b0;
               for (int i = 1; i <= N; i++)
                  if (!found && req[(last + i) % N]) begin
                     found = 1'b1;
                     last = (last + i) % N;
                     exp_grant[last] = 1'b1;
                  end
            end else if (wd_term) mode = M_LST;
         end else if (m_rise) begin
            mode = M_UNL;
            edges = 1;
         end
         wd = m_rise ? 0 : (wd < WD ? wd + 1 : WD);
         exp_locked = mode == M_LCK;
         exp_lost   = mode == M_LST;
         hist.push_back(slow_clk);
         if (hist.size() > 4) void'(hist.pop_front());
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge fast_clk) begin
      if (chk_en) begin
         check("tick", 32'(tick), 32'(exp_tick));
         check("grant", 32'(grant), 32'(exp_grant));
         check("locked", 32'(locked), 32'(exp_locked));
         check("lost", 32'(lost), 32'(exp_lost));
      end
   end

   task automatic wait_tick(output logic [N-1:0] g);
      for (int k = 0; k < 400; k++) begin
         @(negedge fast_clk);
         if (tick) break;
      end
      check("tick_seen", 32'(tick), 1);
      g = grant;
   endtask

   task automatic wait_locked(output int ticks);
      ticks = 0;
      for (int k = 0; k < 800; k++) begin
         @(negedge fast_clk);
         if (locked) break;
         if (tick) ticks++;
      end
      check("lock_seen", 32'(locked), 1);
   endtask

   logic [N-1:0] g;
   logic [N-1:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   int           pt, cyc;
   bit           rel_level;

   initial begin
      #5 rst = 1'b1;
      chk_en = 1'b1;
      #25;
      check("rst_tick", 32'(tick), 0);
      check("rst_grant", 32'(grant), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_lost", 32'(lost), 0);
      #37 rst = 1'b0;
      slow_run = 1'b1;
      n_slow = 0;
      wait_locked(pt);
      check("pre_lock_ticks", 32'(pt), 0);
      check("rises_to_lock", 32'(n_slow), 4);
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_tick(g);
         check("rr_seq", 32'(g), 32'(rr_seq[i]));
         @(negedge fast_clk);
         check("tick_width", 32'(tick), 0);
      end
      req = 4'b0000;
      wait_tick(g);
      check("zero_req_grant", 32'(g), 0);
      req = 4'b0100;
      wait_tick(g);
      check("single_req_grant", 32'(g), 32'(4'b0100));
      repeat (600) begin
         @(negedge fast_clk);
         if ($urandom_range(0, 3) == 0) req = N'($urandom);
      end
      req = 4'b1011;
      wait_tick(g);
      slow_run = 1'b0;
`ifdef SYN_SCHED_WDOG_EN
      cyc = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge fast_clk);
         if (lost) break;
         cyc++;
      end
      check("lost_set", 32'(lost), 1);
      check("lost_unlocked", 32'(locked), 0);
      check("lost_delay", 32'(cyc >= WD - 4 && cyc <= WD + 6), 1);
      repeat (20) @(negedge fast_clk);
      n_slow = 0;
      slow_run = 1'b1;
      wait_locked(pt);
      check("relock_rises", 32'(n_slow), 4);
`else
      repeat (200) @(negedge fast_clk);
      check("stopped_locked", 32'(locked), 1);
      check("stopped_lost", 32'(lost), 0);
      slow_run = 1'b1;
`endif
      repeat (150) begin
         @(negedge fast_clk);
         if ($urandom_range(0, 2) == 0) req = N'($urandom);
      end
      req = 4'b1111;
      wait_tick(g);
      #0.25 rst = 1'b1;
      #1;
      check("rst_mid_tick", 32'(tick), 0);
      check("rst_mid_grant", 32'(grant), 0);
      check("rst_mid_locked", 32'(locked), 0);
      check("rst_mid_lost", 32'(lost), 0);
      #2 rst = 1'b0;
      rel_level = slow_clk;
      n_slow = 0;
      wait_locked(pt);
      check("post_rst_rises", 32'(n_slow), rel_level ? 3 : 4);
      wait_tick(g);
      check("post_rst_first_grant", 32'(g), 32'(4'b0001));
      repeat (10) @(negedge fast_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
